otter_bus_interconnect: RTL and testbench

- Parametrised shared-bus interconnect for the OTTER CPU. It connects NUM_INIT bus initiators (core, debug, DMA) to NUM_TGT targets (memory, MMIO, CSR peripherals).
- Adds round-robin arbitration, mask/base address decode, unmapped-address error responses and a hung-target timeout. Only one transaction is in flight at a time.
- Sits between the core-side buses and the memory/peripheral buses in the cpu top level.

---
 rtl/otter_bus_interconnect_if.sv | 42 ++++
 rtl/otter_bus_interconnect.sv | 181 ++++++++++++++++++
 tb/tb_otter_bus_interconnect.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/otter_bus_interconnect_if.sv
// Bus bundle between the OTTER initiators, the shared-bus interconnect and its targets.
// slave is the interconnect's view; master is the view of the initiators/targets around it.
interface otter_bus_interconnect_if #(
  parameter int unsigned NUM_INIT = 2,
  parameter int unsigned NUM_TGT  = 4,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32
);
  localparam int unsigned BW = DW / 8;

  logic [NUM_INIT-1:0]    i_req;
  logic [NUM_INIT*AW-1:0] i_addr;
  logic [NUM_INIT-1:0]    i_we;
  logic [NUM_INIT*BW-1:0] i_be;
  logic [NUM_INIT*DW-1:0] i_wdata;
  logic [NUM_INIT*DW-1:0] i_rdata;
  logic [NUM_INIT-1:0]    i_ack;
  logic [NUM_INIT-1:0]    i_err;

  logic [NUM_TGT-1:0]     t_req;
  logic [AW-1:0]          t_addr;
  logic                   t_we;
  logic [BW-1:0]          t_be;
  logic [DW-1:0]          t_wdata;
  logic [NUM_TGT*DW-1:0]  t_rdata;
  logic [NUM_TGT-1:0]     t_ack;
  logic [NUM_TGT-1:0]     t_err;

  modport slave (
    input  i_req, i_addr, i_we, i_be, i_wdata,
    output i_rdata, i_ack, i_err,
    output t_req, t_addr, t_we, t_be, t_wdata,
    input  t_rdata, t_ack, t_err
  );

  modport master (
    output i_req, i_addr, i_we, i_be, i_wdata,
    input  i_rdata, i_ack, i_err,
    input  t_req, t_addr, t_we, t_be, t_wdata,
    output t_rdata, t_ack, t_err
  );
endinterface

// File: rtl/otter_bus_interconnect.sv
// Shared-bus interconnect: round-robin arbitration, mask/base decode, error on unmapped
// addresses and a hung-target timeout, with one transaction in flight at a time.
module otter_bus_interconnect #(
  parameter int unsigned             NUM_INIT = 2,
  parameter int unsigned             NUM_TGT  = 4,
  parameter int unsigned             AW       = 32,
  parameter int unsigned             DW       = 32,
  parameter logic [NUM_TGT*AW-1:0]   TGT_BASE = '0,
  parameter logic [NUM_TGT*AW-1:0]   TGT_MASK = '0,
  parameter int unsigned             TIMEOUT  = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  otter_bus_interconnect_if.slave    bus
);
  localparam int unsigned BW = DW / 8;
  localparam int unsigned PW = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1;
  localparam int unsigned TW = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, DECODE = 2'd1, ACTIVE = 2'd2, ERROR = 2'd3} state_e;

  state_e        state_q;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] gnt_q;
  logic [TW-1:0] tgt_q;
  logic [CW-1:0] cnt_q;

  logic          arb_vld;
  logic [PW-1:0] arb_idx;
  logic [31:0]   scan;
  logic [AW-1:0] g_addr;
  logic          g_we;
  logic [BW-1:0] g_be;
  logic [DW-1:0] g_wdata;
  logic          dec_hit;
  logic [TW-1:0] dec_idx;
  logic          sel_ack;
  logic          sel_err;
  logic [DW-1:0] sel_rdata;
  logic          active;
  logic          expire;
  logic [PW-1:0] nxt_ptr;

  // Round-robin pick: first requester at or after the pointer, wrapping.
  always_comb begin
    arb_vld = 1'b0;
    arb_idx = '0;
    scan    = '0;
    for (int k = 0; k < int'(NUM_INIT); k++) begin
      scan = 32'(ptr_q) + 32'(k);
      if (scan >= NUM_INIT) scan = scan - NUM_INIT;
      if (!arb_vld && bus.i_req[PW'(scan)]) begin
        arb_vld = 1'b1;
        arb_idx = PW'(scan);
      end
    end
  end

  always_comb begin
    g_addr  = '0;
    g_we    = 1'b0;
    g_be    = '0;
    g_wdata = '0;
    for (int i = 0; i < int'(NUM_INIT); i++) begin
      if (gnt_q == PW'(i)) begin
        g_addr  = bus.i_addr[i*AW +: AW];
        g_we    = bus.i_we[i];
        g_be    = bus.i_be[i*BW +: BW];
        g_wdata = bus.i_wdata[i*DW +: DW];
      end
    end
  end

  // Lowest-index region wins when regions overlap.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int t = 0; t < int'(NUM_TGT); t++) begin
      if (!dec_hit && ((g_addr & TGT_MASK[t*AW +: AW]) == TGT_BASE[t*AW +: AW])) begin
        dec_hit = 1'b1;
        dec_idx = TW'(t);
      end
    end
  end

  always_comb begin
    sel_ack   = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int t = 0; t < int'(NUM_TGT); t++) begin
      if (tgt_q == TW'(t)) begin
        sel_ack   = bus.t_ack[t];
        sel_err   = bus.t_err[t];
        sel_rdata = bus.t_rdata[t*DW +: DW];
      end
    end
  end

  assign active  = (state_q == ACTIVE);
  assign expire  = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));
  assign nxt_ptr = (gnt_q == PW'(NUM_INIT - 1)) ? '0 : gnt_q + PW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_vld) begin
            gnt_q   <= arb_idx;
            state_q <= DECODE;
          end
        end
        DECODE: begin
          if (dec_hit) begin
            tgt_q   <= dec_idx;
            state_q <= ACTIVE;
          end else begin
            state_q <= ERROR;
          end
        end
        ACTIVE: begin
          if (sel_ack || sel_err || expire) begin
            state_q <= IDLE;
            ptr_q   <= nxt_ptr;
            cnt_q   <= '0;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ERROR: begin
          state_q <= IDLE;
          ptr_q   <= nxt_ptr;
          cnt_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Target response beats expiry; error beats ack.
  always_comb begin
    bus.t_req   = '0;
    bus.t_addr  = '0;
    bus.t_we    = 1'b0;
    bus.t_be    = '0;
    bus.t_wdata = '0;
    bus.i_ack   = '0;
    bus.i_err   = '0;
    bus.i_rdata = '0;
    if (active) begin
      for (int t = 0; t < int'(NUM_TGT); t++) begin
        if (tgt_q == TW'(t)) bus.t_req[t] = 1'b1;
      end
      bus.t_addr  = g_addr;
      bus.t_we    = g_we;
      bus.t_be    = g_be;
      bus.t_wdata = g_wdata;
    end
    for (int i = 0; i < int'(NUM_INIT); i++) begin
      if (gnt_q == PW'(i)) begin
        if (state_q == ERROR) bus.i_err[i] = 1'b1;
        if (active) begin
          if (sel_err) begin
            bus.i_err[i] = 1'b1;
          end else if (sel_ack) begin
            bus.i_ack[i]              = 1'b1;
            bus.i_rdata[i*DW +: DW]   = sel_rdata;
          end else if (expire) begin
            bus.i_err[i] = 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_otter_bus_interconnect.sv
// Self-checking bench for otter_bus_interconnect: directed cases then randomized
// single transactions against a transaction-level reference model.
module tb_otter_bus_interconnect;
  localparam int unsigned NI = 2;
  localparam int unsigned NT = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;
  localparam logic [NT*AW-1:0] BASE_P = {32'h1000_0000, 32'h2000_0000, 32'h1100_0000, 32'h0000_0000};
  localparam logic [NT*AW-1:0] MASK_P = {32'hF000_0000, 32'hF000_0000, 32'hFF00_0000, 32'hF000_0000};

  logic [31:0] rbase [4] = '{32'h0000_0000, 32'h1100_0000, 32'h2000_0000, 32'h1000_0000};
  logic [31:0] rmask [4] = '{32'hF000_0000, 32'hFF00_0000, 32'hF000_0000, 32'hF000_0000};
  int          waits [6] = '{0, 1, 2, 3, 4, 6};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  otter_bus_interconnect_if #(.NUM_INIT(NI), .NUM_TGT(NT), .AW(AW), .DW(DW)) bus ();

  otter_bus_interconnect #(
    .NUM_INIT(NI), .NUM_TGT(NT), .AW(AW), .DW(DW),
    .TGT_BASE(BASE_P), .TGT_MASK(MASK_P), .TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          errors   = 0;
  int          checks   = 0;
  int          tcnt     = 0;
  int          tgt_wait = 0;
  int          tgt_mode = 0;   // 0: ack, 1: err, 2: ack+err together
  int          stray_t  = 0;
  bit          stray_en = 1'b0;
  int          ref_ptr  = 0;
  logic [31:0] rd_word [4];

  // Target model: responds once when it has seen t_req for tgt_wait earlier cycles.
  always @(posedge clk) tcnt <= (|bus.t_req) ? tcnt + 1 : 0;

  always_comb begin
    bus.t_ack = '0;
    bus.t_err = '0;
    for (int t = 0; t < 4; t++) begin
      bus.t_rdata[t*32 +: 32] = rd_word[t];
      if (stray_en && t == stray_t) bus.t_ack[t] = 1'b1;
      if (bus.t_req[t] && tcnt == tgt_wait) begin
        if (tgt_mode != 1) bus.t_ack[t] = 1'b1;
        if (tgt_mode != 0) bus.t_err[t] = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_decode(input logic [31:0] a);
    for (int t = 0; t < 4; t++) if ((a & rmask[t]) == rbase[t]) return t;
    return -1;
  endfunction

  function automatic int rr_pick(input logic [1:0] reqs);
    for (int k = 0; k < int'(NI); k++) if (reqs[(ref_ptr + k) % int'(NI)]) return (ref_ptr + k) % int'(NI);
    return -1;
  endfunction

  // One isolated transaction from initiator ini; expectations from the model.
  task automatic txn(input int ini, input logic [31:0] addr, input logic we, input logic [3:0] be,
                     input logic [31:0] wd, input int wt, input int mode);
    int          t;
    int          exp_cyc;
    int          exp_n;
    int          n_treq = 0;
    int          resp   = -1;
    int          other;
    logic [1:0]  kind   = 2'b00;
    logic [1:0]  exp_kind;
    logic [31:0] rdata  = '0;
    logic [31:0] exp_rd;
    logic [3:0]  oh     = 4'b0000;
    bit          bad_treq = 1'b0, bad_fields = 1'b0, bad_quiet = 1'b0;
    other = 1 - ini;
    t = ref_decode(addr);
    if (t < 0) begin
      exp_cyc = 2; exp_n = 0; exp_kind = 2'b01; exp_rd = '0;
    end else if (wt <= int'(TO)) begin
      oh = 4'b0001 << t;
      exp_cyc = 2 + wt; exp_n = wt + 1;
      exp_kind = (mode == 0) ? 2'b10 : 2'b01;
      exp_rd = (mode == 0) ? rd_word[t] : '0;
    end else begin
      oh = 4'b0001 << t;
      exp_cyc = 2 + int'(TO); exp_n = int'(TO) + 1; exp_kind = 2'b01; exp_rd = '0;
    end
    stray_t  = (t < 0) ? 0 : (t + 1) % 4;
    stray_en = 1'($urandom_range(0, 1));
    tgt_wait = wt;
    tgt_mode = mode;
    @(negedge clk);
    bus.i_addr[ini*32 +: 32]  = addr;
    bus.i_we[ini]             = we;
    bus.i_be[ini*4 +: 4]      = be;
    bus.i_wdata[ini*32 +: 32] = wd;
    bus.i_req[ini]            = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (|bus.t_req) begin
        n_treq++;
        if (bus.t_req !== oh) bad_treq = 1'b1;
        if (bus.t_addr !== addr || bus.t_we !== we || bus.t_be !== be || bus.t_wdata !== wd) bad_fields = 1'b1;
      end else if (bus.t_addr !== '0 || bus.t_we !== 1'b0 || bus.t_be !== '0 || bus.t_wdata !== '0) begin
        bad_fields = 1'b1;
      end
      if (bus.i_ack[other] || bus.i_err[other] || bus.i_rdata[other*32 +: 32] !== '0) bad_quiet = 1'b1;
      if (bus.i_ack[ini] || bus.i_err[ini]) begin
        resp  = c;
        kind  = {bus.i_ack[ini], bus.i_err[ini]};
        rdata = bus.i_rdata[ini*32 +: 32];
        break;
      end else if (bus.i_rdata[ini*32 +: 32] !== '0) begin
        bad_quiet = 1'b1;
      end
    end
    bus.i_req[ini] = 1'b0;
    stray_en = 1'b0;
    @(negedge clk);
    #1;
    chk("resp_cycle", 32'(resp), 32'(exp_cyc));
    chk("resp_kind", 32'(kind), 32'(exp_kind));
    chk("resp_rdata", rdata, exp_rd);
    chk("treq_cycles", 32'(n_treq), 32'(exp_n));
    chk("treq_onehot_bad", 32'(bad_treq), 32'd0);
    chk("tfields_bad", 32'(bad_fields), 32'd0);
    chk("quiet_bad", 32'(bad_quiet), 32'd0);
    chk("single_pulse", 32'({bus.i_ack, bus.i_err, bus.t_req}), 32'd0);
    ref_ptr = (ini + 1) % int'(NI);
  endtask

  initial begin
    int          nack;
    int          got;
    int          exp_i;
    int          r;
    logic [31:0] a;
    logic [31:0] arb_addr [2];

    rd_word[0] = 32'hA0A0_0000;
    rd_word[1] = 32'hDEAD_BEEF;
    rd_word[2] = 32'h2222_CAFE;
    rd_word[3] = 32'h3333_F00D;
    bus.i_req = '0; bus.i_addr = '0; bus.i_we = '0; bus.i_be = '0; bus.i_wdata = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_treq", 32'(bus.t_req), 32'd0);
    chk("rst_resp", 32'({bus.i_ack, bus.i_err}), 32'd0);
    chk("rst_tfields", bus.t_addr | bus.t_wdata | 32'({bus.t_we, bus.t_be}), 32'd0);
    chk("rst_rdata", bus.i_rdata[31:0] | bus.i_rdata[63:32], 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    txn(0, 32'h1100_0010, 1'b0, 4'hF, 32'h0, 2, 0);             // read, 2 wait cycles
    txn(1, 32'h0000_0040, 1'b1, 4'b0011, 32'h1234_5678, 1, 0);  // write to target 0
    txn(0, 32'hF000_0000, 1'b0, 4'hF, 32'h0, 0, 0);             // unmapped
    txn(1, 32'h2000_0008, 1'b0, 4'hF, 32'h0, 100, 0);           // hung target
    txn(1, 32'h2000_000C, 1'b0, 4'hF, 32'h0, 0, 0);             // served normally after timeout
    txn(0, 32'h1000_0000, 1'b0, 4'hF, 32'h0, 0, 1);             // target error
    txn(0, 32'h1100_0000, 1'b0, 4'hF, 32'h0, int'(TO), 2);      // ack+err on expiry cycle, overlap region

    // Reset mid-transaction (pointer is 1 at this point)
    @(negedge clk);
    bus.i_addr[63:32] = 32'h2000_0010; bus.i_we[1] = 1'b0; bus.i_be[7:4] = 4'hF;
    bus.i_req[1] = 1'b1; tgt_wait = 3; tgt_mode = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_treq", 32'(bus.t_req), 32'h4);
    rst = 1'b1;
    #1;
    chk("async_rst_treq", 32'(bus.t_req), 32'd0);
    chk("async_rst_taddr", bus.t_addr, 32'd0);
    chk("async_rst_resp", 32'({bus.i_ack, bus.i_err}), 32'd0);
    bus.i_req = '0;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_hold_resp", 32'({bus.i_ack, bus.i_err}), 32'd0);
    end
    ref_ptr = 0;

    // Both initiators requesting continuously
    arb_addr[0] = 32'h0000_0100;
    arb_addr[1] = 32'h2000_0200;
    rst = 1'b0;
    tgt_wait = 0; tgt_mode = 0;
    bus.i_addr = {arb_addr[1], arb_addr[0]};
    bus.i_we = '0; bus.i_be = '1;
    bus.i_req = 2'b11;
    nack = 0;
    for (int c = 0; c < 60 && nack < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (bus.i_ack != '0 || bus.i_err != '0) begin
        got   = bus.i_ack[1] ? 1 : 0;
        exp_i = rr_pick(2'b11);
        if (nack == 0) chk("arb_first_grant", 32'(got), 32'd0);
        chk("arb_grant", 32'(got), 32'(exp_i));
        chk("arb_ack_pattern", 32'({bus.i_ack, bus.i_err}), 32'(2'b01 << (2 + exp_i)));
        chk("arb_rdata", bus.i_rdata[got*32 +: 32], rd_word[ref_decode(arb_addr[exp_i])]);
        chk("arb_cycle", 32'(c), 32'(2 + 3 * nack));
        ref_ptr = (exp_i + 1) % int'(NI);
        nack++;
      end
    end
    bus.i_req = '0;
    chk("arb_count", 32'(nack), 32'd6);
    @(negedge clk);

    // Randomized single transactions
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 4; k++) rd_word[k] = $urandom;
      r = $urandom_range(0, 4);
      a = $urandom;
      case (r)
        0: a = {4'h0, a[27:0]};
        1: a = {8'h11, a[23:0]};
        2: a = {4'h2, a[27:0]};
        3: a = {4'h1, a[27:0]};
        default: a = {4'($urandom_range(3, 15)), a[27:0]};
      endcase
      r = $urandom_range(0, 9);
      txn($urandom_range(0, 1), a, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom,
          waits[$urandom_range(0, 5)], (r < 7) ? 0 : ((r < 9) ? 1 : 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
